fir_decimator: RTL and testbench
================================

FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 The block SHALL have parameter TAPS, default 32 (MAX_TAPS), meaning the filter length; legal range 1..MAX_TAPS.
REQ-002 The block SHALL have parameter DECIM, default 8 (AUDIO_DECIM), meaning the number of accepted input samples per output sample; legal range 1..TAPS.
REQ-003 The block SHALL have parameter COEFFS, default all zero, meaning TAPS signed 32-bit Q(BITS) coefficients, COEFFS[0] applied to the newest sample.
REQ-004 The block SHALL have port clock, input, 1 bit, the single rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit, with synchronous, active-high reset.
REQ-006 The block SHALL have port in_data, input, 32 bits, a signed Q(BITS) sample.
REQ-007 The block SHALL have port in_valid, input, 1 bit, asserted when in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, asserted when the block accepts a sample this cycle.
REQ-009 The block SHALL have port out_data, output, 32 bits, the signed Q(BITS) filtered sample.
REQ-010 The block SHALL have port out_valid, output, 1 bit, asserted when out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, asserted when the downstream stage accepts out_data.

Function
REQ-012 A transfer SHALL occur on a cycle where valid and ready are both high; no other cycle transfers data.
REQ-013 The FSM SHALL have states S_LOAD, S_MAC and S_OUT; in_ready = (state == S_LOAD) and not reset; out_valid = (state == S_OUT).
REQ-014 In S_LOAD, each accepted sample SHALL shift into a TAPS-entry history (newest at x[0], oldest discarded) and increment a decimation counter.
REQ-015 When the accepted sample brings the counter to DECIM, the counter SHALL wrap to 0 and the state SHALL go to S_MAC on the next edge.
REQ-016 S_MAC SHALL process one tap per cycle for exactly TAPS cycles and then enter S_OUT.
REQ-017 The per-tap arithmetic SHALL be: the 64-bit signed product COEFFS[i]*x[i], divided by QUANT_VAL (2^BITS) with truncation toward zero (DEQUANTIZE semantics), truncated to 32 bits, then added into a 32-bit accumulator that wraps on overflow.
REQ-018 The accumulator SHALL clear on entry to S_MAC, and out_data SHALL be registered from it on entry to S_OUT.
REQ-019 In S_OUT, out_data SHALL hold stable until out_ready is high, after which the state SHALL return to S_LOAD on the next edge.
REQ-020 in_valid SHALL be ignored outside S_LOAD, so no sample is lost or duplicated under backpressure.
REQ-021 Latency from the accepting edge of the DECIM-th sample to out_valid high SHALL be TAPS+1 cycles.
REQ-022 The history SHALL start at zero, and partial-history outputs SHALL use those zeros.

Reset
REQ-023 On reset, state SHALL go to S_LOAD; history, counter, accumulator and out_data SHALL go to 0; out_valid and in_ready SHALL be 0 while reset is high.
REQ-024 Reset asserted mid-S_MAC or mid-S_OUT SHALL abandon the computation without emitting it; the first output after reset SHALL need DECIM fresh samples.

Structure
REQ-025 BITS, QUANT_VAL, MAX_TAPS, AUDIO_DECIM, the DEQUANTIZE function and a 32-bit coefficient-array typedef SHALL live in the shared macros package.
REQ-026 The block SHALL be a single module with no sub-module; an input FIFO, if needed, belongs to the upstream stage.

Verification
REQ-027 Impulse test: TAPS=32, DECIM=8, distinct COEFFS; feed 7 zeros, then 1024, then zeros with out_ready=1 -> outputs are COEFFS[0], COEFFS[8], COEFFS[16], COEFFS[24], then 0.
REQ-028 DC test: all COEFFS=128 and in_data constantly 1024 -> outputs are 1024, 2048, 3072, then 4096 steady.
REQ-029 Rounding test: COEFFS[0]=-1 and x=1 as the sole nonzero sample -> out_data=0, not -1; COEFFS[0]=2048 and x=-3 -> out_data=-6.
REQ-030 Backpressure test: hold out_ready=0 for 10 cycles in S_OUT -> out_valid stays 1, out_data is unchanged, in_ready=0, and upstream samples are neither accepted nor lost.
REQ-031 Latency test: after the 8th sample is accepted, out_valid rises exactly 33 cycles later.
REQ-032 Reset test: assert reset at cycle 10 of S_MAC -> no output is emitted, and the next output equals that of a fresh run.

Source files
------------

// File: rtl/fir_decimator_pkg.sv
// rtl/fir_decimator_pkg.sv - shared fixed-point constants, types and helpers for the FIR decimator
package fir_decimator_pkg;

    localparam int BITS        = 10;
    localparam logic signed [63:0] QUANT_VAL = 64'sd1 <<< BITS;
    localparam int MAX_TAPS    = 32;
    localparam int AUDIO_DECIM = 8;
    localparam int COEFF_IW    = $clog2(MAX_TAPS);

    typedef logic signed [31:0] coeff_array_t [MAX_TAPS];

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    // Signed division rounds toward zero, so tiny negative products become 0, not -1.
    function automatic logic signed [31:0] DEQUANTIZE(input logic signed [63:0] p);
        logic signed [63:0] q;
        q = p / QUANT_VAL;
        return q[31:0];
    endfunction

endpackage

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - decimating FIR: collect DECIM samples, then one tap per cycle MAC, then hold output
module fir_decimator
    import fir_decimator_pkg::*;
#(
    parameter int           TAPS   = MAX_TAPS,
    parameter int           DECIM  = AUDIO_DECIM,
    parameter coeff_array_t COEFFS = '{default: '0}
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [31:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CW = $clog2(TAPS + 1);
    localparam int DW = $clog2(DECIM + 1);
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    state_t             state_q, state_d;
    logic signed [31:0] x_q [TAPS];
    logic [DW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      tap_q, tap_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] out_q, out_d;
    logic [IW-1:0]      tap_idx;
    logic signed [63:0] prod;
    logic               shift;

    always_comb begin
        tap_idx = (tap_q < CW'(TAPS)) ? IW'(tap_q) : '0;
        prod    = COEFFS[COEFF_IW'(tap_idx)] * x_q[tap_idx];
    end

    // tap_q runs 0..TAPS-1 accumulating; at tap_q == TAPS the finished sum is written back.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        out_d     = out_q;
        shift     = 1'b0;
        in_ready  = (state_q == S_LOAD) && !reset;
        out_valid = (state_q == S_OUT);
        unique case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    shift = 1'b1;
                    if (cnt_q == DW'(DECIM - 1)) begin
                        cnt_d   = '0;
                        tap_d   = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                if (tap_q == CW'(TAPS)) begin
                    out_d   = acc_q;
                    state_d = S_OUT;
                end else begin
                    acc_d = acc_q + DEQUANTIZE(prod);
                    tap_d = tap_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            if (shift) begin
                x_q[0] <= in_data;
                for (int i = 1; i < TAPS; i++) begin
                    x_q[i] <= x_q[i-1];
                end
            end
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - directed table-driven bench for fir_decimator (impulse, DC, rounding, backpressure, latency, reset)
module tb_fir_decimator;
    import fir_decimator_pkg::*;

    // Impulse coefficients: c[i] = (-1)^i * (100 + 17*i)
    localparam coeff_array_t IMP_C = '{
        100, -117, 134, -151, 168, -185, 202, -219,
        236, -253, 270, -287, 304, -321, 338, -355,
        372, -389, 406, -423, 440, -457, 474, -491,
        508, -525, 542, -559, 576, -593, 610, -627};
    localparam coeff_array_t DC_C   = '{default: 128};
    localparam coeff_array_t RNDA_C = '{0: -1, default: 0};
    localparam coeff_array_t RNDB_C = '{0: 2048, default: 0};

    logic               clock;
    logic               reset;
    logic signed [31:0] in_data   [4];
    logic               in_valid  [4];
    logic               in_ready  [4];
    logic signed [31:0] out_data  [4];
    logic               out_valid [4];
    logic               out_ready [4];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int                 d;
        int                 n;
        logic signed [31:0] fill;
        int                 pos;
        logic signed [31:0] val;
        logic signed [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    fir_decimator #(.TAPS(32), .DECIM(8), .COEFFS(IMP_C)) u_imp (
        .clock(clock), .reset(reset),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

    fir_decimator #(.TAPS(32), .DECIM(8), .COEFFS(DC_C)) u_dc (
        .clock(clock), .reset(reset),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

    fir_decimator #(.TAPS(1), .DECIM(1), .COEFFS(RNDA_C)) u_rnda (
        .clock(clock), .reset(reset),
        .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

    fir_decimator #(.TAPS(1), .DECIM(1), .COEFFS(RNDB_C)) u_rndb (
        .clock(clock), .reset(reset),
        .in_data(in_data[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .out_data(out_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int d, input logic signed [31:0] v);
        int n = 0;
        in_data[d]  = v;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready[d]) begin
            check("send_timeout", 32'(in_ready[d]), 1);
        end
        @(negedge clock);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output logic signed [31:0] data, output bit ok);
        int n = 0;
        while (!out_valid[d] && n < 100) begin
            @(negedge clock);
            n++;
        end
        ok   = out_valid[d];
        data = out_data[d];
    endtask

    task automatic run_block(input vec_t v, input string name);
        logic signed [31:0] data;
        bit                 ok;
        out_ready[v.d] = 1'b1;
        for (int j = 0; j < v.n; j++) begin
            send(v.d, (j == v.pos) ? v.val : v.fill);
        end
        wait_out(v.d, data, ok);
        check({name, "_valid"}, 32'(ok), 1);
        check(name, data, v.exp);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic signed [31:0] data;
        logic signed [31:0] held;
        bit                 ok;
        int                 lat;
        bit                 seen;

        reset = 1'b1;
        for (int d = 0; d < 4; d++) begin
            in_data[d]   = '0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end

        // Reset state
        repeat (3) @(negedge clock);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_in_ready[%0d]", d), 32'(in_ready[d]), 0);
            check($sformatf("rst_out_valid[%0d]", d), 32'(out_valid[d]), 0);
        end
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_out_data[%0d]", d), out_data[d], 0);
            check($sformatf("post_rst_in_ready[%0d]", d), 32'(in_ready[d]), 1);
        end

        // Impulse: 7 zeros then 1024, then zeros
        tbl.push_back('{0, 8, 0,  7, 1024, 100});
        tbl.push_back('{0, 8, 0, -1,    0, 236});
        tbl.push_back('{0, 8, 0, -1,    0, 372});
        tbl.push_back('{0, 8, 0, -1,    0, 508});
        tbl.push_back('{0, 8, 0, -1,    0,   0});
        // DC: constant 1024 with all coefficients 128
        tbl.push_back('{1, 8, 1024, -1, 0, 1024});
        tbl.push_back('{1, 8, 1024, -1, 0, 2048});
        tbl.push_back('{1, 8, 1024, -1, 0, 3072});
        tbl.push_back('{1, 8, 1024, -1, 0, 4096});
        tbl.push_back('{1, 8, 1024, -1, 0, 4096});
        // Rounding toward zero, coefficient -1
        tbl.push_back('{2, 1,     1, -1, 0,  0});
        tbl.push_back('{2, 1, -1025, -1, 0,  1});
        tbl.push_back('{2, 1,  1025, -1, 0, -1});
        // Coefficient 2048 (x2)
        tbl.push_back('{3, 1, -3, -1, 0, -6});
        tbl.push_back('{3, 1,  7, -1, 0, 14});
        tbl.push_back('{3, 1, -1, -1, 0, -2});

        foreach (tbl[k]) begin
            run_block(tbl[k], $sformatf("tbl[%0d]", k));
        end

        // Latency: 8th sample accept edge to out_valid high
        do_reset();
        out_ready[0] = 1'b1;
        for (int j = 0; j < 7; j++) send(0, 0);
        in_data[0]  = 1024;
        in_valid[0] = 1'b1;
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clock);
            lat++;
            #1;
            if (out_valid[0]) break;
        end
        check("latency", lat, 33);
        check("latency_data", out_data[0], 100);
        @(negedge clock);
        @(negedge clock);

        // Backpressure: hold S_OUT for 10 cycles while upstream offers a sample
        do_reset();
        out_ready[1] = 1'b0;
        for (int j = 0; j < 8; j++) send(1, 1024);
        wait_out(1, held, ok);
        check("bp_valid", 32'(ok), 1);
        check("bp_data", held, 1024);
        in_data[1]  = 512;
        in_valid[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check($sformatf("bp_hold_valid[%0d]", c), 32'(out_valid[1]), 1);
            check($sformatf("bp_hold_data[%0d]", c), out_data[1], held);
            check($sformatf("bp_hold_in_ready[%0d]", c), 32'(in_ready[1]), 0);
        end
        out_ready[1] = 1'b1;
        @(negedge clock);
        check("bp_resume_ready", 32'(in_ready[1]), 1);
        @(negedge clock);
        in_valid[1] = 1'b0;
        for (int j = 0; j < 7; j++) send(1, 512);
        wait_out(1, data, ok);
        check("bp_next_valid", 32'(ok), 1);
        check("bp_next_data", data, 1536);
        @(negedge clock);

        // Reset at cycle 10 of S_MAC abandons the computation
        do_reset();
        out_ready[0] = 1'b1;
        for (int j = 0; j < 7; j++) send(0, 0);
        in_data[0]  = 1024;
        in_valid[0] = 1'b1;
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (out_valid[0]) seen = 1'b1;
        end
        check("rst_mac_no_output", 32'(seen), 0);
        check("rst_mac_in_ready", 32'(in_ready[0]), 1);
        run_block('{0, 8, 0, 7, 1024, 100}, "rst_mac_fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
